// File: rtl/mult_sequencer_pkg.sv
// Shared definitions for the sequential multiplier slice.
//  - state_t   : FSM state encoding used by mult_sequencer
//  - DISP_*    : display codes driven on state_out; seven_segment_encoder
//                decodes the same values (0..3 progress, >=4 renders "E")
//  - DEFAULT_* : default operand width and error display code
//  - disp_code : maps an FSM state to its state_out display code
package mult_sequencer_pkg;

  localparam int          DEFAULT_WIDTH    = 8;
  localparam logic [2:0]  DEFAULT_ERR_CODE = 3'd4;

  localparam logic [2:0]  DISP_IDLE = 3'd0;
  localparam logic [2:0]  DISP_LSB  = 3'd1;
  localparam logic [2:0]  DISP_MID  = 3'd2;
  localparam logic [2:0]  DISP_MSB  = 3'd3;
  localparam logic [2:0]  DISP_DONE = 3'd0;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LSB       = 3'd1,
    MID       = 3'd2,
    MSB       = 3'd3,
    CALC_DONE = 3'd4,
    ERR       = 3'd5
  } state_t;

  // ERR shows a configurable code so the display can be retargeted without
  // touching the FSM encoding.
  function automatic logic [2:0] disp_code(input state_t s, input logic [2:0] err_code);
    case (s)
      LSB:       disp_code = DISP_LSB;
      MID:       disp_code = DISP_MID;
      MSB:       disp_code = DISP_MSB;
      CALC_DONE: disp_code = DISP_DONE;
      ERR:       disp_code = err_code;
      default:   disp_code = DISP_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/mult_sequencer_if.sv
// Operand/result bundle between the switch/button front end and the
// multiplier core.
//  start      : level start request (core acts on its rising edge)
//  dataa      : multiplicand, WIDTH bits
//  datab      : multiplier, WIDTH bits
//  product    : last completed product, 2*WIDTH bits
//  done_flag  : one-cycle completion pulse
//  state_out  : 3-bit display code for seven_segment_encoder
// master: the side supplying operands; slave: the multiplier core.
interface mult_sequencer_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     dataa;
  logic [WIDTH-1:0]     datab;
  logic [2*WIDTH-1:0]   product;
  logic                 done_flag;
  logic [2:0]           state_out;

  modport master (
    output start, dataa, datab,
    input  product, done_flag, state_out
  );

  modport slave (
    input  start, dataa, datab,
    output product, done_flag, state_out
  );
endinterface

// File: rtl/mult_sequencer_mult4x4.sv
// Purely combinational HALF x HALF unsigned multiplier.
//  a, b : HALF-bit unsigned operands
//  p    : 2*HALF-bit unsigned product
module mult_sequencer_mult4x4 #(
  parameter int HALF = 4
) (
  input  logic [HALF-1:0]   a,
  input  logic [HALF-1:0]   b,
  output logic [2*HALF-1:0] p
);
  assign p = {{HALF{1'b0}}, a} * {{HALF{1'b0}}, b};
endmodule

// File: rtl/mult_sequencer.sv
// Control and datapath core of the WIDTH x WIDTH sequential multiplier.
// The product is assembled from four HALF x HALF partial products, one per
// accumulate cycle, using a single shared mult_sequencer_mult4x4.
// Ports:
//  clk      : rising-edge clock
//  reset_a  : asynchronous reset, active-low
//  bus      : slave side of mult_sequencer_if (start, dataa, datab in;
//             product, done_flag, state_out out; all outputs registered)
// Parameters:
//  WIDTH    : operand width, must be even
//  ERR_CODE : state_out value shown while in ERR
module mult_sequencer
  import mult_sequencer_pkg::*;
#(
  parameter int         WIDTH    = DEFAULT_WIDTH,
  parameter logic [2:0] ERR_CODE = DEFAULT_ERR_CODE
) (
  input  logic             clk,
  input  logic             reset_a,
  mult_sequencer_if.slave  bus
);

  localparam int HALF = WIDTH / 2;

  state_t               state;
  logic                 start_d;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [2*WIDTH-1:0]   acc;
  logic [1:0]           count;
  logic [2*WIDTH-1:0]   product_q;
  logic                 done_q;
  logic [2:0]           state_out_q;

  logic                 trig;
  logic [HALF-1:0]      op_a;
  logic [HALF-1:0]      op_b;
  logic [2*HALF-1:0]    pp;
  logic [2*WIDTH-1:0]   pp_ext;
  logic [2*WIDTH-1:0]   pp_shifted;
  logic [2*WIDTH-1:0]   acc_sum;

  // Only a rising edge of start is a request; a held level never retriggers.
  assign trig = bus.start & ~start_d;

  // Nibble selection and weighting follow the accumulate count:
  //  0: lo*lo << 0, 1: lo*hi << HALF, 2: hi*lo << HALF, 3: hi*hi << WIDTH
  always_comb begin
    op_a       = a_q[HALF-1:0];
    op_b       = b_q[HALF-1:0];
    pp_shifted = pp_ext;
    case (count)
      2'd1: begin
        op_b       = b_q[WIDTH-1:HALF];
        pp_shifted = pp_ext << HALF;
      end
      2'd2: begin
        op_a       = a_q[WIDTH-1:HALF];
        pp_shifted = pp_ext << HALF;
      end
      2'd3: begin
        op_a       = a_q[WIDTH-1:HALF];
        op_b       = b_q[WIDTH-1:HALF];
        pp_shifted = pp_ext << WIDTH;
      end
      default: ;
    endcase
  end

  mult_sequencer_mult4x4 #(
    .HALF (HALF)
  ) u_mult4x4 (
    .a (op_a),
    .b (op_b),
    .p (pp)
  );

  assign pp_ext  = {{(2*WIDTH-2*HALF){1'b0}}, pp};
  // Sum of all four weighted partials is < 2^(2*WIDTH), so no carry out.
  assign acc_sum = acc + pp_shifted;

  // Control, operand capture and accumulation: one registered FSM whose
  // outputs (product, done_flag, state_out) are set alongside the state.
  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      state       <= IDLE;
      start_d     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      acc         <= '0;
      count       <= '0;
      product_q   <= '0;
      done_q      <= 1'b0;
      state_out_q <= DISP_IDLE;
    end else begin
      start_d <= bus.start;
      done_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (trig) begin
            a_q         <= bus.dataa;
            b_q         <= bus.datab;
            acc         <= '0;
            count       <= '0;
            state       <= LSB;
            state_out_q <= disp_code(LSB, ERR_CODE);
          end
        end

        LSB, MID, MSB: begin
          if (trig) begin
            // A new request mid-operation aborts it; the previous product
            // stays on display.
            acc         <= '0;
            count       <= '0;
            state       <= ERR;
            state_out_q <= disp_code(ERR, ERR_CODE);
          end else begin
            acc   <= acc_sum;
            count <= count + 2'd1;
            case (count)
              2'd0: begin
                state       <= MID;
                state_out_q <= disp_code(MID, ERR_CODE);
              end
              2'd1: begin
                state       <= MID;
                state_out_q <= disp_code(MID, ERR_CODE);
              end
              2'd2: begin
                state       <= MSB;
                state_out_q <= disp_code(MSB, ERR_CODE);
              end
              default: begin
                product_q   <= acc_sum;
                done_q      <= 1'b1;
                state       <= CALC_DONE;
                state_out_q <= disp_code(CALC_DONE, ERR_CODE);
              end
            endcase
          end
        end

        CALC_DONE: begin
          state       <= IDLE;
          state_out_q <= disp_code(IDLE, ERR_CODE);
        end

        ERR: begin
          // start must be low before leaving, so no trig can coincide with
          // the return to IDLE.
          if (!bus.start) begin
            state       <= IDLE;
            state_out_q <= disp_code(IDLE, ERR_CODE);
          end
        end

        default: begin
          state       <= IDLE;
          state_out_q <= DISP_IDLE;
        end
      endcase
    end
  end

  assign bus.product   = product_q;
  assign bus.done_flag = done_q;
  assign bus.state_out = state_out_q;

endmodule

// File: tb/tb_mult_sequencer.sv
module tb_mult_sequencer;

  logic clk;
  logic reset_a;
  int   checks;
  int   failures;

  mult_sequencer_if #(.WIDTH(8)) bus ();

  mult_sequencer #(
    .WIDTH    (8),
    .ERR_CODE (3'd4)
  ) dut (
    .clk     (clk),
    .reset_a (reset_a),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Raise start with the given operands, then follow the five cycles of the
  // operation. When scramble is set, the operands are overwritten every cycle
  // after the trigger.
  task automatic run_mult(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp, input bit scramble);
    logic [2:0] seq [5];
    seq = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd0};
    @(negedge clk);
    bus.dataa = a;
    bus.datab = b;
    bus.start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("%s_state%0d", tag, i), 32'(bus.state_out), 32'(seq[i]));
      check($sformatf("%s_done%0d", tag, i), 32'(bus.done_flag), (i == 4) ? 32'd1 : 32'd0);
      if (scramble) begin
        bus.dataa = 8'($urandom);
        bus.datab = 8'($urandom);
      end
    end
    check({tag, "_product"}, 32'(bus.product), 32'(exp));
    bus.start = 1'b0;
    @(negedge clk);
    check({tag, "_done_clear"}, 32'(bus.done_flag), 32'd0);
    check({tag, "_product_hold"}, 32'(bus.product), 32'(exp));
  endtask

  initial begin
    int pulses;
    checks   = 0;
    failures = 0;
    reset_a  = 1'b0;
    bus.start = 1'b0;
    bus.dataa = '0;
    bus.datab = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_product", 32'(bus.product), 32'd0);
    check("rst_done", 32'(bus.done_flag), 32'd0);
    check("rst_state", 32'(bus.state_out), 32'd0);
    reset_a = 1'b1;
    @(negedge clk);

    // Basic multiply and operand extremes
    run_mult("t1", 8'h12, 8'h34, 16'h03A8, 1'b0);
    run_mult("t2a", 8'hFF, 8'hFF, 16'hFE01, 1'b0);
    run_mult("t2b", 8'h00, 8'hAB, 16'h0000, 1'b0);

    // Held start: a single operation and a single done pulse
    @(negedge clk);
    bus.dataa = 8'h80;
    bus.datab = 8'h02;
    bus.start = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done_flag) pulses++;
    end
    check("t3_pulses", 32'(pulses), 32'd1);
    check("t3_state", 32'(bus.state_out), 32'd0);
    check("t3_product", 32'(bus.product), 32'h0100);
    bus.start = 1'b0;
    @(negedge clk);

    // Retrigger while in MID -> ERR, previous product kept
    bus.dataa = 8'h11;
    bus.datab = 8'h11;
    bus.start = 1'b1;
    @(negedge clk);
    check("t4_lsb", 32'(bus.state_out), 32'd1);
    bus.start = 1'b0;
    @(negedge clk);
    check("t4_mid", 32'(bus.state_out), 32'd2);
    bus.start = 1'b1;
    @(negedge clk);
    check("t4_err", 32'(bus.state_out), 32'd4);
    check("t4_err_product", 32'(bus.product), 32'h0100);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("t4_err_hold%0d", i), 32'(bus.state_out), 32'd4);
    end
    bus.start = 1'b0;
    @(negedge clk);
    check("t4_idle", 32'(bus.state_out), 32'd0);
    check("t4_product", 32'(bus.product), 32'h0100);
    check("t4_done", 32'(bus.done_flag), 32'd0);

    // Operands changing after the trigger are ignored
    run_mult("t5", 8'hA5, 8'h3C, 16'h26AC, 1'b1);

    // Async reset in MSB clears outputs without a clock edge
    @(negedge clk);
    bus.dataa = 8'h12;
    bus.datab = 8'h34;
    bus.start = 1'b1;
    repeat (4) @(negedge clk);
    check("t6_msb", 32'(bus.state_out), 32'd3);
    #2 reset_a = 1'b0;
    #1;
    check("t6_rst_product", 32'(bus.product), 32'd0);
    check("t6_rst_done", 32'(bus.done_flag), 32'd0);
    check("t6_rst_state", 32'(bus.state_out), 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    reset_a = 1'b1;
    @(negedge clk);
    run_mult("t6_after", 8'h07, 8'h09, 16'h003F, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
